// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART FIFO bridge: RX entry layout and
// default FIFO depths.
package uart_pkg;

    localparam int TX_DEPTH_DEFAULT = 16;
    localparam int RX_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       frame_err;
        logic       parity_err;
    } rx_entry_t;

    localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock show-ahead FIFO with flush and a drop strobe that
// fires when a push is refused.
module uart_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem_r [Depth];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic full_s;
    logic empty_s;
    logic do_pop_s;
    logic do_push_s;
    logic drop_s;

    // Handshake decode; a pop frees a slot so a same-cycle push into a full FIFO is accepted.
    always_comb begin
        full_s    = (count_r == CW'(Depth));
        empty_s   = (count_r == CW'(0));
        do_pop_s  = pop_i & ~empty_s;
        do_push_s = push_i & (~full_s | do_pop_s);
        drop_s    = push_i & full_s & ~do_pop_s & ~flush_i;
    end

    // Pointer and occupancy state; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is deliberately left unreset; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_r[rd_ptr_r];
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign count_o   = count_r;
    assign drop_o    = drop_s;

endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-side byte buffering between a bus master and a UART core: a TX FIFO
// feeding the transmitter and an RX FIFO capturing received bytes with flags.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int TxDepth = TX_DEPTH_DEFAULT,
    parameter int RxDepth = RX_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [7:0]                 tx_data_i,
    input  logic                       tx_wr_i,
    output logic                       tx_full_o,
    output logic [$clog2(TxDepth):0]   tx_count_o,
    input  logic                       tx_flush_i,
    output logic [7:0]                 rx_data_o,
    output logic                       rx_frame_err_o,
    output logic                       rx_parity_err_o,
    output logic                       rx_empty_o,
    input  logic                       rx_rd_i,
    output logic [$clog2(RxDepth):0]   rx_count_o,
    input  logic                       rx_flush_i,
    output logic                       rx_overflow_o,
    output logic                       tx_overflow_o,
    input  logic                       ovf_clr_i,
    output logic [7:0]                 uart_data_o,
    output logic                       uart_data_valid_o,
    input  logic                       uart_data_in_ready_i,
    input  logic [7:0]                 uart_data_i,
    input  logic                       uart_data_valid_i,
    input  logic                       uart_frame_error_i,
    input  logic                       uart_parity_error_i
);

    logic      tx_empty_s;
    logic      tx_drop_s;
    logic      rx_drop_s;
    logic      rx_full_s;
    logic      tx_ovf_r;
    logic      rx_ovf_r;
    rx_entry_t rx_wr_s;
    rx_entry_t rx_head_s;

    assign rx_wr_s = '{data: uart_data_i, frame_err: uart_frame_error_i,
                       parity_err: uart_parity_error_i};

    // The transmitter pops on its ready; the pop is qualified by non-empty inside the FIFO.
    uart_sync_fifo #(
        .Width (8),
        .Depth (TxDepth)
    ) u_tx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (tx_wr_i),
        .wr_data_i (tx_data_i),
        .pop_i     (uart_data_in_ready_i),
        .flush_i   (tx_flush_i),
        .rd_data_o (uart_data_o),
        .full_o    (tx_full_o),
        .empty_o   (tx_empty_s),
        .count_o   (tx_count_o),
        .drop_o    (tx_drop_s)
    );

    uart_sync_fifo #(
        .Width (RX_ENTRY_W),
        .Depth (RxDepth)
    ) u_rx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (uart_data_valid_i),
        .wr_data_i (rx_wr_s),
        .pop_i     (rx_rd_i),
        .flush_i   (rx_flush_i),
        .rd_data_o (rx_head_s),
        .full_o    (rx_full_s),
        .empty_o   (rx_empty_o),
        .count_o   (rx_count_o),
        .drop_o    (rx_drop_s)
    );

    // Valid depends only on registered occupancy, so ready never loops back into it.
    assign uart_data_valid_o = ~tx_empty_s;
    assign rx_data_o         = rx_head_s.data;
    assign rx_frame_err_o    = rx_head_s.frame_err;
    assign rx_parity_err_o   = rx_head_s.parity_err;

    // Sticky overflow flags; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_ovf_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            if (tx_drop_s) begin
                tx_ovf_r <= 1'b1;
            end else if (ovf_clr_i) begin
                tx_ovf_r <= 1'b0;
            end else begin
                tx_ovf_r <= tx_ovf_r;
            end
            if (rx_drop_s) begin
                rx_ovf_r <= 1'b1;
            end else if (ovf_clr_i) begin
                rx_ovf_r <= 1'b0;
            end else begin
                rx_ovf_r <= rx_ovf_r;
            end
        end
    end

    assign tx_overflow_o = tx_ovf_r;
    assign rx_overflow_o = rx_ovf_r;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: directed stimulus queues expected
// bytes, independent monitors compare them as the DUT hands them out.
module tb_uart_fifo_bridge;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic [7:0] tx_data_i;
    logic       tx_wr_i;
    logic       tx_full_o;
    logic [4:0] tx_count_o;
    logic       tx_flush_i;
    logic [7:0] rx_data_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;
    logic       rx_empty_o;
    logic       rx_rd_i;
    logic [4:0] rx_count_o;
    logic       rx_flush_i;
    logic       rx_overflow_o;
    logic       tx_overflow_o;
    logic       ovf_clr_i;
    logic [7:0] uart_data_o;
    logic       uart_data_valid_o;
    logic       uart_data_in_ready_i;
    logic [7:0] uart_data_i;
    logic       uart_data_valid_i;
    logic       uart_frame_error_i;
    logic       uart_parity_error_i;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_q[$];
    logic [9:0] rx_q[$];

    uart_fifo_bridge dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .tx_data_i            (tx_data_i),
        .tx_wr_i              (tx_wr_i),
        .tx_full_o            (tx_full_o),
        .tx_count_o           (tx_count_o),
        .tx_flush_i           (tx_flush_i),
        .rx_data_o            (rx_data_o),
        .rx_frame_err_o       (rx_frame_err_o),
        .rx_parity_err_o      (rx_parity_err_o),
        .rx_empty_o           (rx_empty_o),
        .rx_rd_i              (rx_rd_i),
        .rx_count_o           (rx_count_o),
        .rx_flush_i           (rx_flush_i),
        .rx_overflow_o        (rx_overflow_o),
        .tx_overflow_o        (tx_overflow_o),
        .ovf_clr_i            (ovf_clr_i),
        .uart_data_o          (uart_data_o),
        .uart_data_valid_o    (uart_data_valid_o),
        .uart_data_in_ready_i (uart_data_in_ready_i),
        .uart_data_i          (uart_data_i),
        .uart_data_valid_i    (uart_data_valid_i),
        .uart_frame_error_i   (uart_frame_error_i),
        .uart_parity_error_i  (uart_parity_error_i)
    );

    // 10 ns system clock.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx_count"}, 32'(tx_count_o), 32'd0);
        chk({tag, "_rx_count"}, 32'(rx_count_o), 32'd0);
        chk({tag, "_rx_empty"}, 32'(rx_empty_o), 32'd1);
        chk({tag, "_tx_full"}, 32'(tx_full_o), 32'd0);
        chk({tag, "_valid"}, 32'(uart_data_valid_o), 32'd0);
        chk({tag, "_tx_ovf"}, 32'(tx_overflow_o), 32'd0);
        chk({tag, "_rx_ovf"}, 32'(rx_overflow_o), 32'd0);
    endtask

    // Monitors: compare transfers on the falling edge, between active edges.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && uart_data_valid_o === 1'b1 && uart_data_in_ready_i === 1'b1) begin
            if (tx_q.size() == 0) begin
                chk("tx_unexpected_valid", 32'(uart_data_valid_o), 32'd0);
            end else begin
                chk("tx_byte", 32'(uart_data_o), 32'(tx_q.pop_front()));
            end
        end
        if (reset_n_i === 1'b1 && rx_rd_i === 1'b1 && rx_empty_o === 1'b0) begin
            if (rx_q.size() == 0) begin
                chk("rx_unexpected_entry", 32'(rx_empty_o), 32'd1);
            end else begin
                chk("rx_entry", 32'({rx_data_o, rx_frame_err_o, rx_parity_err_o}),
                    32'(rx_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n_i = 1'b0;
        tx_data_i = 8'h00; tx_wr_i = 1'b0; tx_flush_i = 1'b0;
        rx_rd_i = 1'b0; rx_flush_i = 1'b0; ovf_clr_i = 1'b0;
        uart_data_in_ready_i = 1'b0; uart_data_i = 8'h00; uart_data_valid_i = 1'b0;
        uart_frame_error_i = 1'b0; uart_parity_error_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_state("reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();

        // Three bytes streamed with the transmitter always ready.
        uart_data_in_ready_i = 1'b1;
        foreach (tx_q[i]) tx_q.delete(i);
        begin
            logic [7:0] seq [3];
            seq[0] = 8'h55; seq[1] = 8'hAA; seq[2] = 8'h0F;
            for (int i = 0; i < 3; i++) begin
                tx_data_i = seq[i];
                tx_wr_i = 1'b1;
                tx_q.push_back(seq[i]);
                tick();
            end
        end
        tx_wr_i = 1'b0;
        repeat (4) tick();
        chk("stream_tx_count", 32'(tx_count_o), 32'd0);
        chk("stream_valid", 32'(uart_data_valid_o), 32'd0);
        chk("stream_q_drained", 32'(tx_q.size()), 32'd0);

        // Fill TX with the transmitter stalled, then overflow it.
        uart_data_in_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tx_data_i = 8'h10 + 8'(i);
            tx_wr_i = 1'b1;
            if (i < 16) tx_q.push_back(8'h10 + 8'(i));
            tick();
            if (i == 15) begin
                chk("fill_full", 32'(tx_full_o), 32'd1);
                chk("fill_count", 32'(tx_count_o), 32'd16);
                chk("fill_no_ovf", 32'(tx_overflow_o), 32'd0);
            end
        end
        tx_wr_i = 1'b0;
        chk("drop_tx_ovf", 32'(tx_overflow_o), 32'd1);
        chk("drop_tx_count", 32'(tx_count_o), 32'd16);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("clr_tx_ovf", 32'(tx_overflow_o), 32'd0);
        // Drop coinciding with clear keeps the flag set.
        tx_wr_i = 1'b1; tx_data_i = 8'h99; ovf_clr_i = 1'b1;
        tick();
        tx_wr_i = 1'b0; ovf_clr_i = 1'b0;
        chk("clr_vs_drop_ovf", 32'(tx_overflow_o), 32'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("clr2_tx_ovf", 32'(tx_overflow_o), 32'd0);
        // Push and pop together while full: push accepted, count unchanged.
        tx_wr_i = 1'b1; tx_data_i = 8'hC3; uart_data_in_ready_i = 1'b1;
        tx_q.push_back(8'hC3);
        tick();
        tx_wr_i = 1'b0;
        chk("full_pushpop_count", 32'(tx_count_o), 32'd16);
        chk("full_pushpop_ovf", 32'(tx_overflow_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (tx_count_o == 5'd0) break;
            tick();
        end
        chk("drain_tx_count", 32'(tx_count_o), 32'd0);
        chk("drain_q_empty", 32'(tx_q.size()), 32'd0);

        // Flush wins over a same-cycle write.
        uart_data_in_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_data_i = 8'h60 + 8'(i);
            tx_wr_i = 1'b1;
            tick();
        end
        chk("flush_pre_count", 32'(tx_count_o), 32'd5);
        tx_flush_i = 1'b1; tx_data_i = 8'hEE;
        tick();
        tx_flush_i = 1'b0; tx_wr_i = 1'b0;
        tx_q.delete();
        chk("flush_tx_count", 32'(tx_count_o), 32'd0);
        chk("flush_valid", 32'(uart_data_valid_o), 32'd0);
        chk("flush_no_ovf", 32'(tx_overflow_o), 32'd0);
        uart_data_in_ready_i = 1'b1;
        repeat (3) tick();
        uart_data_in_ready_i = 1'b0;

        // Single RX strobe with a frame error.
        uart_data_i = 8'h3C; uart_frame_error_i = 1'b1; uart_parity_error_i = 1'b0;
        uart_data_valid_i = 1'b1;
        rx_q.push_back({8'h3C, 1'b1, 1'b0});
        tick();
        uart_data_valid_i = 1'b0; uart_frame_error_i = 1'b0;
        chk("rx1_empty", 32'(rx_empty_o), 32'd0);
        chk("rx1_data", 32'(rx_data_o), 32'h3C);
        chk("rx1_frame", 32'(rx_frame_err_o), 32'd1);
        chk("rx1_parity", 32'(rx_parity_err_o), 32'd0);
        chk("rx1_count", 32'(rx_count_o), 32'd1);
        rx_rd_i = 1'b1;
        tick();
        chk("rx1_pop_empty", 32'(rx_empty_o), 32'd1);
        tick();
        rx_rd_i = 1'b0;
        chk("rx_rd_when_empty_count", 32'(rx_count_o), 32'd0);
        chk("rx_rd_when_empty_ovf", 32'(rx_overflow_o), 32'd0);

        // Fill RX with varied flags, then exercise the full boundary.
        for (int i = 0; i < 16; i++) begin
            uart_data_i = 8'hA0 + 8'(i);
            uart_frame_error_i = i[0];
            uart_parity_error_i = i[1];
            uart_data_valid_i = 1'b1;
            rx_q.push_back({8'hA0 + 8'(i), i[0], i[1]});
            tick();
        end
        uart_data_valid_i = 1'b0; uart_frame_error_i = 1'b0; uart_parity_error_i = 1'b0;
        chk("rxfull_count", 32'(rx_count_o), 32'd16);
        uart_data_i = 8'hEE; uart_data_valid_i = 1'b1; rx_rd_i = 1'b1;
        rx_q.push_back({8'hEE, 1'b0, 1'b0});
        tick();
        rx_rd_i = 1'b0;
        chk("rxfull_pushpop_count", 32'(rx_count_o), 32'd16);
        chk("rxfull_pushpop_ovf", 32'(rx_overflow_o), 32'd0);
        uart_data_i = 8'h77;
        tick();
        uart_data_valid_i = 1'b0;
        chk("rx_drop_ovf", 32'(rx_overflow_o), 32'd1);
        chk("rx_drop_count", 32'(rx_count_o), 32'd16);
        chk("rx_drop_head", 32'({rx_data_o, rx_frame_err_o, rx_parity_err_o}),
            32'({8'hA1, 1'b1, 1'b0}));
        rx_rd_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rx_empty_o) break;
            tick();
        end
        tick();
        rx_rd_i = 1'b0;
        chk("rx_drain_empty", 32'(rx_empty_o), 32'd1);
        chk("rx_drain_q", 32'(rx_q.size()), 32'd0);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("clr_rx_ovf", 32'(rx_overflow_o), 32'd0);

        // RX flush overrides a same-cycle strobe.
        for (int i = 0; i < 3; i++) begin
            uart_data_i = 8'h40 + 8'(i);
            uart_data_valid_i = 1'b1;
            tick();
        end
        rx_flush_i = 1'b1;
        tick();
        rx_flush_i = 1'b0; uart_data_valid_i = 1'b0;
        chk("rx_flush_count", 32'(rx_count_o), 32'd0);
        chk("rx_flush_empty", 32'(rx_empty_o), 32'd1);

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 3; i++) begin
            tx_data_i = 8'h80 + 8'(i);
            tx_wr_i = 1'b1;
            uart_data_i = 8'h90 + 8'(i);
            uart_data_valid_i = 1'b1;
            tick();
        end
        tx_wr_i = 1'b0; uart_data_valid_i = 1'b0;
        chk("pre_reset_tx_count", 32'(tx_count_o), 32'd3);
        #2;
        reset_n_i = 1'b0;
        tx_q.delete();
        rx_q.delete();
        #1;
        chk_reset_state("async_reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        chk("post_reset_tx_count", 32'(tx_count_o), 32'd0);
        chk("post_reset_rx_empty", 32'(rx_empty_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
